// File: rtl/tx_baseband_transmitter_if.sv
// Input sample stream for tx_baseband_transmitter: signed I/Q pair with valid/ready handshake.
interface tx_baseband_transmitter_if;
  logic signed [15:0] s_tdata_i;
  logic signed [15:0] s_tdata_q;
  logic               s_tvalid;
  logic               s_tready;

  modport master (output s_tdata_i, output s_tdata_q, output s_tvalid, input s_tready);
  modport slave  (input s_tdata_i, input s_tdata_q, input s_tvalid, output s_tready);
endinterface

// File: rtl/tx_baseband_transmitter.sv
// Baseband TX: I/Q FIFO, zero-order-hold interpolation, LO mixing to a real 16-bit DAC stream.
// Optional TX_DIGITAL_GAIN_EN adds a tx_gain port and a third (gain) pipeline stage.
module tx_baseband_transmitter #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned INTERP_FACTOR = 4,
  parameter int unsigned START_LEVEL   = 8
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          enable,
  tx_baseband_transmitter_if.slave      s_in,
  input  logic signed [15:0]            lo_cos,
  input  logic signed [15:0]            lo_sin,
  input  logic                          clear_status,
`ifdef TX_DIGITAL_GAIN_EN
  input  logic [15:0]                   tx_gain,
`endif
  output logic signed [15:0]            data_out,
  output logic                          data_out_valid,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned SW = (INTERP_FACTOR > 1) ? $clog2(INTERP_FACTOR) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_e;

  // ---------------- FIFO ----------------
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level;
  logic          full, empty, push, pop;
  logic signed [15:0] head_i, head_q;

  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    full     = (level == LW'(FIFO_DEPTH));
    empty    = (level == '0);
    push     = s_in.s_tvalid && !full;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    head_i   = mem_q[rd_ptr_q[AW-1:0]][31:16];
    head_q   = mem_q[rd_ptr_q[AW-1:0]][15:0];
  end

  assign s_in.s_tready = !full;
  assign fifo_level    = level;

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s_in.s_tdata_i, s_in.s_tdata_q};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ---------------- Control FSM ----------------
  state_e             state_q, state_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic signed [15:0] hold_i_q, hold_i_d, hold_q_q, hold_q_d;
  logic               underflow_q, underflow_d;
  logic               set_uf, wrap;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    hold_i_d = hold_i_q;
    hold_q_d = hold_q_q;
    pop      = 1'b0;
    set_uf   = 1'b0;
    wrap     = (slot_q == SW'(INTERP_FACTOR - 1));
    case (state_q)
      ST_IDLE: begin
        hold_i_d = '0;
        hold_q_d = '0;
        slot_d   = '0;
        if (enable) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        hold_i_d = '0;
        hold_q_d = '0;
        slot_d   = '0;
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (level >= LW'(START_LEVEL)) begin
          pop      = 1'b1;
          hold_i_d = head_i;
          hold_q_d = head_q;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wrap) begin
          // Disable is only honoured at a slot boundary so a sample is never cut short.
          slot_d = '0;
          if (!enable) begin
            hold_i_d = '0;
            hold_q_d = '0;
            state_d  = ST_IDLE;
          end else if (empty) begin
            hold_i_d = '0;
            hold_q_d = '0;
            set_uf   = 1'b1;
            state_d  = ST_PRIME;
          end else begin
            pop      = 1'b1;
            hold_i_d = head_i;
            hold_q_d = head_q;
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    underflow_d = underflow_q;
    if (clear_status) underflow_d = 1'b0;
    if (set_uf)       underflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      hold_i_q    <= hold_i_d;
      hold_q_q    <= hold_q_d;
      underflow_q <= underflow_d;
    end
  end

  assign underflow = underflow_q;

  // ---------------- Mixer datapath ----------------
  logic signed [31:0] pi_q, pi_d, pq_q, pq_d;
  logic               v1_q, v1_d, v2_q, v2_d;
  logic signed [33:0] diff;
  logic signed [18:0] rnd;

  always_comb begin
    pi_d = 32'(hold_i_q) * 32'(lo_cos);
    pq_d = 32'(hold_q_q) * 32'(lo_sin);
    v1_d = (state_q == ST_RUN);
    v2_d = v1_q;
    diff = 34'(pi_q) - 34'(pq_q) + 34'sd16384;
    rnd  = 19'(diff >>> 15);
  end

`ifdef TX_DIGITAL_GAIN_EN
  logic signed [18:0] r_q, r_d;
  logic signed [15:0] dout_q, dout_d;
  logic               v3_q, v3_d;
  logic signed [35:0] gprod;
  logic signed [20:0] gshift;

  always_comb begin
    r_d    = rnd;
    v3_d   = v2_q;
    gprod  = 36'(r_q) * 36'($signed({1'b0, tx_gain})) + 36'sd16384;
    gshift = 21'(gprod >>> 15);
    if (gshift > 21'sd32767)       dout_d = 16'sh7fff;
    else if (gshift < -21'sd32768) dout_d = 16'sh8000;
    else                           dout_d = gshift[15:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pi_q <= '0; pq_q <= '0; r_q <= '0; dout_q <= '0;
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
    end else begin
      pi_q <= pi_d; pq_q <= pq_d; r_q <= r_d; dout_q <= dout_d;
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
    end
  end

  assign data_out_valid = v3_q;
`else
  logic signed [15:0] dout_q, dout_d;

  always_comb begin
    if (rnd > 19'sd32767)       dout_d = 16'sh7fff;
    else if (rnd < -19'sd32768) dout_d = 16'sh8000;
    else                        dout_d = rnd[15:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pi_q <= '0; pq_q <= '0; dout_q <= '0;
      v1_q <= 1'b0; v2_q <= 1'b0;
    end else begin
      pi_q <= pi_d; pq_q <= pq_d; dout_q <= dout_d;
      v1_q <= v1_d; v2_q <= v2_d;
    end
  end

  assign data_out_valid = v2_q;
`endif

  assign data_out = dout_q;

endmodule

// File: tb/tb_tx_baseband_transmitter.sv
// Directed table-driven bench for tx_baseband_transmitter (default build, no gain stage).
module tb_tx_baseband_transmitter;
  logic               clock = 1'b0;
  logic               resetn, enable, clear_status;
  logic signed [15:0] lo_cos, lo_sin, data_out;
  logic               data_out_valid, underflow;
  logic [4:0]         fifo_level;

  tx_baseband_transmitter_if s_if ();

  tx_baseband_transmitter #(.FIFO_DEPTH(16), .INTERP_FACTOR(4), .START_LEVEL(8)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .s_in(s_if),
    .lo_cos(lo_cos), .lo_sin(lo_sin), .clear_status(clear_status),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .underflow(underflow), .fifo_level(fifo_level));

  always #5 clock = ~clock;

  typedef struct {
    logic signed [15:0] i, q, c, s, want;
  } vec_t;

  vec_t tv [8];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input int i, input int q, input int c, input int s, input int w);
    vec_t v;
    v.i = 16'(i); v.q = 16'(q); v.c = 16'(c); v.s = 16'(s); v.want = 16'(w);
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic signed [15:0] i, input logic signed [15:0] q);
    s_if.s_tdata_i = i;
    s_if.s_tdata_q = q;
    s_if.s_tvalid  = 1'b1;
    tick();
    s_if.s_tvalid  = 1'b0;
  endtask

  initial begin
    tv[0] = mk(16384, 0, 32767, 0, 16384);
    tv[1] = mk(-32768, 32767, -32768, -32768, 32767);
    tv[2] = mk(32767, -32768, -32768, -32768, -32768);
    tv[3] = mk(1000, 0, 16384, 0, 500);
    tv[4] = mk(1, 0, 16384, 0, 1);
    tv[5] = mk(-1, 0, 16384, 0, 0);
    tv[6] = mk(0, 1000, 0, 16384, -500);
    tv[7] = mk(10000, -20000, 32767, 16384, 20000);

    resetn = 1'b0; enable = 1'b0; clear_status = 1'b0;
    lo_cos = '0; lo_sin = '0;
    s_if.s_tdata_i = '0; s_if.s_tdata_q = '0; s_if.s_tvalid = 1'b0;
    @(negedge clock);
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_tready", s_if.s_tready, 1);
    chk("rst_level", fifo_level, 0);
    tick();
    resetn = 1'b1;
    tick();

    // Table run: 8 samples, each held 4 slots, LO changed per sample, then underflow.
    for (int v = 0; v < 8; v++) push(tv[v].i, tv[v].q);
    chk("level_after_8", fifo_level, 8);
    enable = 1'b1; lo_cos = tv[0].c; lo_sin = tv[0].s;
    tick();
    tick();
    for (int c = 0; c < 36; c++) begin
      if (c < 32) begin
        lo_cos = tv[c/4].c;
        lo_sin = tv[c/4].s;
      end
      @(negedge clock);
      if (c >= 2 && c < 34) begin
        chk($sformatf("tbl_valid_%0d", c), data_out_valid, 1);
        chk($sformatf("tbl_data_%0d", c), data_out, tv[(c-2)/4].want);
      end else if (c >= 34) begin
        chk("post_uf_valid", data_out_valid, 0);
        chk("post_uf_data", data_out, 0);
      end
      if (c == 31) chk("uf_before", underflow, 0);
      if (c == 32) begin
        chk("uf_set", underflow, 1);
        chk("uf_level", fifo_level, 0);
      end
      @(posedge clock);
      #1;
    end
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    @(negedge clock);
    chk("uf_cleared", underflow, 0);
    tick();

    // Fill to full while idle; 17th word refused; full push+pop keeps FULL-1.
    enable = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) push(16'((k + 1) * 100), 16'sd0);
    @(negedge clock);
    chk("full_level", fifo_level, 16);
    chk("full_tready", s_if.s_tready, 0);
    @(posedge clock); #1;
    s_if.s_tdata_i = 16'sd9999; s_if.s_tvalid = 1'b1;
    tick();
    chk("refuse_17th", fifo_level, 16);
    enable = 1'b1; lo_cos = 16'sd32767; lo_sin = 16'sd0;
    tick();
    chk("prime_level", fifo_level, 16);
    tick();
    s_if.s_tvalid = 1'b0;
    @(negedge clock);
    chk("first_pop_level", fifo_level, 15);

    // Drop enable at slot 1: slots 2,3 still produce output, then IDLE without a pop.
    for (int c = 1; c < 7; c++) begin
      @(posedge clock); #1;
      if (c == 1) enable = 1'b0;
      @(negedge clock);
      if (c >= 2 && c <= 5) begin
        chk($sformatf("drain_valid_%0d", c), data_out_valid, 1);
        chk($sformatf("drain_data_%0d", c), data_out, 100);
      end
      if (c == 6) begin
        chk("idle_valid", data_out_valid, 0);
        chk("idle_data", data_out, 0);
        chk("idle_level", fifo_level, 15);
      end
    end
    @(posedge clock); #1;
    enable = 1'b1;
    tick();
    tick();
    @(negedge clock);
    chk("resume_level", fifo_level, 14);
    tick();
    tick();
    @(negedge clock);
    chk("resume_valid", data_out_valid, 1);
    chk("resume_data", data_out, 200);

    // Asynchronous reset mid-RUN takes effect before the next edge.
    #2 resetn = 1'b0;
    #1;
    chk("arst_level", fifo_level, 0);
    chk("arst_data", data_out, 0);
    chk("arst_valid", data_out_valid, 0);
    chk("arst_uf", underflow, 0);
    enable = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    @(negedge clock);
    chk("arst_tready", s_if.s_tready, 1);
    chk("arst_idle_valid", data_out_valid, 0);

    // Underflow with clear_status held high: set wins on the underflow cycle.
    @(posedge clock); #1;
    for (int v = 0; v < 8; v++) push(16'sd100, 16'sd0);
    enable = 1'b1; clear_status = 1'b1;
    tick();
    tick();
    for (int c = 0; c < 34; c++) begin
      @(negedge clock);
      if (c == 32) chk("uf_set_wins", underflow, 1);
      if (c == 33) chk("uf_clear_next", underflow, 0);
      @(posedge clock); #1;
    end
    clear_status = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
